// File: rtl/tetromino_rd_arb.sv
// Round-robin read arbiter for BRAM port 0 of the tetromino shape/colour store.
// Optional macro TETRO_RD_BOUNDS_CHECK_EN answers out-of-range reads with rsp_err instead of a BRAM access.
module tetromino_rd_arb #(
    parameter int DWIDTH    = 32,
    parameter int AWIDTH    = 4,
    parameter int MEM_DEPTH = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic              rsp_err,
    output logic [AWIDTH-1:0] bram_addr0,
    output logic              bram_ce0,
    output logic              bram_we0,
    output logic [DWIDTH-1:0] bram_d0,
    input  logic [DWIDTH-1:0] bram_q0
);

    typedef enum logic [1:0] {IDLE, RD, CAP, RSP} state_t;

    localparam logic [AWIDTH:0] DEPTH_LIM = (AWIDTH+1)'(MEM_DEPTH);

    // A depth larger than the address space cannot be addressed at all.
    if (MEM_DEPTH > (1 << AWIDTH)) begin : g_depth_check
        $error("tetromino_rd_arb: MEM_DEPTH exceeds the AWIDTH address space");
    end

    state_t            state, state_nxt;
    logic              cur_id;
    logic              last_grant;
    logic [AWIDTH-1:0] cur_addr;
    logic              grant0, grant1;
    logic              accept;
    logic              accept_id;
    logic [AWIDTH-1:0] accept_addr;
    logic              accept_oob;
    logic              rsp_hs;

    // On contention the requester that was not served last wins.
    always_comb begin
        grant0      = req0_valid && (!req1_valid || last_grant);
        grant1      = req1_valid && (!req0_valid || !last_grant);
        req0_ready  = (state == IDLE) && grant0;
        req1_ready  = (state == IDLE) && grant1;
        accept      = req0_ready || req1_ready;
        accept_id   = req1_ready;
        accept_addr = req1_ready ? req1_addr : req0_addr;
`ifdef TETRO_RD_BOUNDS_CHECK_EN
        accept_oob  = ({1'b0, accept_addr} >= DEPTH_LIM);
`else
        accept_oob  = 1'b0;
`endif
        rsp_hs      = (state == RSP) && (cur_id ? rsp1_ready : rsp0_ready);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = accept_oob ? RSP : RD;
            RD:   state_nxt = CAP;
            CAP:  state_nxt = RSP;
            RSP:  if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_id     <= 1'b0;
            cur_addr   <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            cur_id     <= accept_id;
            cur_addr   <= accept_addr;
            last_grant <= accept_id;
        end
    end

    // Response word is held from CAP (or an out-of-range accept) until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rsp_data <= '0;
        else if (state == CAP)          rsp_data <= bram_q0;
        else if (accept && accept_oob)  rsp_data <= '0;
    end

`ifdef TETRO_RD_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     rsp_err <= 1'b0;
        else if (state == CAP)          rsp_err <= 1'b0;
        else if (accept && accept_oob)  rsp_err <= 1'b1;
    end
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp0_valid = (state == RSP) && !cur_id;
    assign rsp1_valid = (state == RSP) &&  cur_id;
    assign bram_ce0   = (state == RD);
    assign bram_addr0 = cur_addr;
    assign bram_we0   = 1'b0;
    assign bram_d0    = '0;

endmodule

// File: tb/tb_tetromino_rd_arb.sv
// Directed self-checking bench for tetromino_rd_arb with a 1-cycle-latency BRAM model.
// Bounds expectations follow TETRO_RD_BOUNDS_CHECK_EN when it is defined for the build.
module tb_tetromino_rd_arb;

    localparam int DWIDTH = 32;
    localparam int AWIDTH = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req0_valid = 1'b0;
    logic [AWIDTH-1:0] req0_addr = '0;
    logic              req0_ready;
    logic              req1_valid = 1'b0;
    logic [AWIDTH-1:0] req1_addr = '0;
    logic              req1_ready;
    logic              rsp0_valid;
    logic              rsp0_ready = 1'b0;
    logic              rsp1_valid;
    logic              rsp1_ready = 1'b0;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_err;
    logic [AWIDTH-1:0] bram_addr0;
    logic              bram_ce0;
    logic              bram_we0;
    logic [DWIDTH-1:0] bram_d0;
    logic [DWIDTH-1:0] bram_q0 = '0;

    logic [DWIDTH-1:0] mem [16];
    int checks = 0;
    int fails  = 0;

    tetromino_rd_arb #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_DEPTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .bram_addr0(bram_addr0), .bram_ce0(bram_ce0), .bram_we0(bram_we0),
        .bram_d0(bram_d0), .bram_q0(bram_q0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_ce0) bram_q0 <= mem[bram_addr0];
    end

    // The write side of port 0 must never move.
    always @(negedge clk) begin
        checks++;
        if (bram_we0 !== 1'b0 || bram_d0 !== '0) begin
            fails++;
            $display("[TB] FAIL write_port_idle: we0=%b d0=%h required 0/0", bram_we0, bram_d0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, bram_ce0, rsp_err} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL reset_ctrl: got %b required 000000",
                     {req0_ready, req1_ready, rsp0_valid, rsp1_valid, bram_ce0, rsp_err});
        end
        checks++;
        if (rsp_data !== 32'h0 || bram_addr0 !== 4'h0) begin
            fails++;
            $display("[TB] FAIL reset_data: data=%h addr=%h required 0/0", rsp_data, bram_addr0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 4'd3; rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_ready: got %b%b required 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (bram_ce0 !== 1'b1 || bram_addr0 !== 4'd3 || rsp0_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_rd: ce=%b addr=%0d rsp0=%b required 1/3/0", bram_ce0, bram_addr0, rsp0_valid);
        end
        step();
        checks++;
        if (bram_ce0 !== 1'b0 || rsp0_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_cap: ce=%b rsp0=%b required 0/0", bram_ce0, rsp0_valid);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_data !== 32'h00F0_0005 || rsp_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_rsp: v=%b%b data=%h err=%b required 10/00f00005/0",
                     rsp0_valid, rsp1_valid, rsp_data, rsp_err);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_done: rsp0=%b required 0", rsp0_valid);
        end
    endtask

    task automatic test_contention();
        logic [31:0] exp_data;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 4'd1;
        req1_valid = 1'b1; req1_addr = 4'd2;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic id;
            id = k[0];
            exp_data = id ? 32'h2222_0002 : 32'h1111_0001;
            checks++;
            if (req0_ready !== !id || req1_ready !== id) begin
                fails++;
                $display("[TB] FAIL contention_grant%0d: got %b%b required %b%b", k, req0_ready, req1_ready, !id, id);
            end
            step();
            checks++;
            if (bram_ce0 !== 1'b1 || bram_addr0 !== (id ? 4'd2 : 4'd1) || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL contention_rd%0d: ce=%b addr=%0d rdy=%b%b", k, bram_ce0, bram_addr0, req0_ready, req1_ready);
            end
            step();
            step();
            checks++;
            if (rsp0_valid !== !id || rsp1_valid !== id || rsp_data !== exp_data || rsp_err !== 1'b0) begin
                fails++;
                $display("[TB] FAIL contention_rsp%0d: v=%b%b data=%h required %b%b/%h",
                         k, rsp0_valid, rsp1_valid, rsp_data, !id, id, exp_data);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        req1_valid = 1'b1; req1_addr = 4'd7; rsp1_ready = 1'b0; rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_grant1: got %b required 1", req1_ready);
        end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 4'd5;
        step();
        step();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (rsp1_valid !== 1'b1 || rsp_data !== 32'h7777_0007 || req0_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL bp_hold%0d: v1=%b data=%h rdy0=%b required 1/77770007/0",
                         c, rsp1_valid, rsp_data, req0_ready);
            end
            if (c < 5) step();
        end
        rsp1_ready = 1'b1;
        step();
        checks++;
        if (rsp1_valid !== 1'b0 || req0_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bp_release: v1=%b rdy0=%b required 0/1", rsp1_valid, req0_ready);
        end
        step();
        req0_valid = 1'b0;
        step();
        step();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 32'h5555_0005) begin
            fails++;
            $display("[TB] FAIL bp_next_rsp: v0=%b data=%h required 1/55550005", rsp0_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_addr = 4'd4; rsp0_ready = 1'b1;
        #1;
        step();
        req0_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0 || bram_ce0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_outputs: v=%b%b data=%h err=%b ce=%b required 00/0/0/0",
                     rsp0_valid, rsp1_valid, rsp_data, rsp_err, bram_ce0);
        end
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (rsp0_valid !== 1'b0 || rsp_data !== 32'h0) begin
                fails++;
                $display("[TB] FAIL midreset_no_rsp%0d: v0=%b data=%h required 0/0", c, rsp0_valid, rsp_data);
            end
        end
        req1_valid = 1'b1; req1_addr = 4'd6; rsp1_ready = 1'b1;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset_grant1: got %b%b required 01", req0_ready, req1_ready);
        end
        step();
        req1_valid = 1'b0;
        step();
        step();
        checks++;
        if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_data !== 32'h6666_0006) begin
            fails++;
            $display("[TB] FAIL midreset_rsp1: v=%b%b data=%h required 01/66660006", rsp0_valid, rsp1_valid, rsp_data);
        end
        step();
    endtask

    task automatic test_bounds();
        req0_valid = 1'b1; req0_addr = 4'd12; rsp0_ready = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL bounds_grant: got %b required 1", req0_ready);
        end
        step();
        req0_valid = 1'b0;
`ifdef TETRO_RD_BOUNDS_CHECK_EN
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b1 || bram_ce0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bounds_oob_rsp: v0=%b data=%h err=%b ce=%b required 1/0/1/0",
                     rsp0_valid, rsp_data, rsp_err, bram_ce0);
        end
        step();
        checks++;
        if (rsp0_valid !== 1'b0 || bram_ce0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bounds_oob_done: v0=%b ce=%b required 0/0", rsp0_valid, bram_ce0);
        end
`else
        checks++;
        if (bram_ce0 !== 1'b1 || bram_addr0 !== 4'd12) begin
            fails++;
            $display("[TB] FAIL bounds_rd: ce=%b addr=%0d required 1/12", bram_ce0, bram_addr0);
        end
        step();
        step();
        checks++;
        if (rsp0_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 32'hCCCC_000C) begin
            fails++;
            $display("[TB] FAIL bounds_rsp: v0=%b err=%b data=%h required 1/0/cccc000c", rsp0_valid, rsp_err, rsp_data);
        end
        step();
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        mem[1]  = 32'h1111_0001;
        mem[2]  = 32'h2222_0002;
        mem[3]  = 32'h00F0_0005;
        mem[4]  = 32'h4444_0004;
        mem[5]  = 32'h5555_0005;
        mem[6]  = 32'h6666_0006;
        mem[7]  = 32'h7777_0007;
        mem[12] = 32'hCCCC_000C;
        $display("[TB] starting tetromino_rd_arb bench");
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_bounds();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tetromino_rd_arb.md
# tetromino_rd_arb

Read arbiter and sequencer for read port 0 of the tetromino shape/colour BRAM. Two requesters share the single synchronous read port:
- requester 0: game logic core, for the active piece.
- requester 1: next-piece preview renderer.

Each request is a one-word read through a valid/ready handshake. The block drives the BRAM control signals, absorbs the 1-cycle BRAM read latency, and returns the word on a held response channel. Grants alternate round-robin; port 1 of the BRAM stays with the AXI4-lite writer and is not touched.

## Interface
- DWIDTH, 32, BRAM word width (shape bitmap + colour).
- AWIDTH, 4, BRAM address width.
- MEM_DEPTH, 10, number of valid BRAM words (addresses 0..MEM_DEPTH-1).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a read pending.
- req0_addr  in  AWIDTH  requester 0 word address.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req1_valid / req1_addr / req1_ready: same as above for requester 1.
- rsp0_valid  out  1  response for requester 0 is on rsp_data/rsp_err.
- rsp0_ready  in  1  requester 0 takes the response.
- rsp1_valid / rsp1_ready: same as above for requester 1.
- rsp_data  out  DWIDTH  read word, meaningful only while rsp0_valid or rsp1_valid is high.
- rsp_err  out  1  out-of-range flag, qualified like rsp_data.
- bram_addr0  out  AWIDTH  BRAM port-0 address.
- bram_ce0  out  1  BRAM port-0 enable.
- bram_we0  out  1  BRAM port-0 write enable, constant 0.
- bram_d0  out  DWIDTH  BRAM port-0 write data, constant 0.
- bram_q0  in  DWIDTH  BRAM port-0 read data, valid the cycle after bram_ce0.

## Operation
- FSM states: IDLE, RD, CAP, RSP.
- **IDLE**
  - Only state in which a reqN_ready can be high; at most one ready is high per cycle.
  - Grant rule:
    - only one valid: that requester is granted.
    - both valid: the requester other than last_grant is granted.
  - req_ready of the granted requester = 1, combinational from the valids.
  - On the handshake edge:
    - capture requester id into cur_id and address into cur_addr.
    - last_grant <= cur_id.
    - go to RD.
- **RD:** bram_ce0=1, bram_addr0=cur_addr; next state CAP.
- **CAP:** bram_q0 is valid; latch rsp_data <= bram_q0, rsp_err <= 0; next state RSP.
- **RSP**
  - rsp{cur_id}_valid=1, the other rsp_valid=0; rsp_data and rsp_err held stable.
  - On rsp{cur_id}_valid && rsp{cur_id}_ready: go to IDLE.
- bram_ce0=0 in every state other than RD; bram_addr0=cur_addr in all states.
- Requester rules:
  - A requester must not deassert valid or change addr before ready.
  - The block never drops or reorders an accepted request; exactly one outstanding request at a time.
- Reset (async, any state, including mid-RD/CAP/RSP):
  - state=IDLE, all rsp_valid=0, rsp_data=0, rsp_err=0, bram_ce0=0, cur_id=0, cur_addr=0.
  - last_grant=1, so requester 0 wins the first contention.
  - An in-flight read is discarded, with no response.

## Timing
- Handshake at edge E0 → RD during (E0,E1) → CAP during (E1,E2) → rsp_valid high from E2.
- Latency: 2 cycles from accept edge to rsp_valid.
- Minimum 4 cycles per request, when rsp_ready is already high: IDLE, RD, CAP, RSP.
- The next accept can occur in the first IDLE cycle after the response handshake.
- Stall: rsp_ready low holds RSP indefinitely with outputs stable; new requests wait with ready=0.
- Fairness under continuous contention: grants alternate 0,1,0,1…; each requester waits at most one other transaction.

## Configuration
- Macro: TETRO_RD_BOUNDS_CHECK_EN.
- **Defined**
  - Accepted address >= MEM_DEPTH skips RD/CAP: IDLE → RSP directly, no BRAM access (bram_ce0 stays 0).
  - Response is rsp_data=0, rsp_err=1; rsp_valid is high 1 cycle after the accept edge.
- **Undefined**
  - All addresses go through RD/CAP unmodified to the BRAM.
  - rsp_err is constant 0.

## Test plan
- Reset, then req0 addr 3 alone, BRAM[3]=0x00F0_0005, rsp0_ready=1:
  - req0_ready=1 in IDLE, bram_ce0=1 exactly one cycle with addr 3.
  - rsp0_valid at accept+2 with rsp_data=0x00F0_0005, rsp1_valid=0.
- req0 and req1 valid continuously, addrs 1 and 2, rsp_ready=1:
  - grant order 0,1,0,1 with 4 cycles per transaction.
  - data matches BRAM[1]/BRAM[2] on the matching rsp channel.
- Response back-pressure, rsp1_ready low for 5 cycles:
  - rsp1_valid and rsp_data stay constant; req0_ready stays 0 until the rsp1 handshake.
- rst_n asserted during CAP:
  - all outputs return to reset values immediately.
  - no response is ever issued; after release, req1 alone is granted normally.
- Bounds, req0 addr 12 with MEM_DEPTH=10:
  - with TETRO_RD_BOUNDS_CHECK_EN: bram_ce0 never high, rsp0_valid 1 cycle after accept, rsp_data=0, rsp_err=1.
  - without TETRO_RD_BOUNDS_CHECK_EN: bram_ce0 pulses with addr 12 and rsp_err=0.
- bram_we0 and bram_d0 checked 0 throughout all scenarios.
